pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//   PWM input-capture channel; the decoding counterpart to the PWM output channels.
//   - Measures period and high time of an external PWM signal in clk_psc_i cycles.
//   - Presents each completed measurement as a one-cycle valid pulse, for readback through the register block.
// PARAMETERS
//   WIDTH     16  width of the period/high counters and outputs
//   FILT_LEN  4   glitch-filter stability length in cycles (used only with PWM_CAP_FILTER_EN)
// PORTS
//   clk_psc_i  in   1      prescaled system clock; sole clock of the block
//   rst_n_i    in   1      reset, asynchronous, active-low
//   en_i       in   1      capture enable; low = IDLE, all measurement state cleared
//   pol_i      in   1      0: active-high pulse measured; 1: input inverted before measuring
//   pwm_i      in   1      asynchronous PWM input pin
//   period_o   out  WIDTH  last measured period (active edge to active edge)
//   high_o     out  WIDTH  last measured active time within that period
//   valid_o    out  1      one-cycle pulse: period_o/high_o updated this cycle
//   busy_o     out  1      1 while in HIGH or LOW state (a measurement is in progress)
//   ovf_o      out  1      sticky: a counter saturated; cleared only when en_i is low
// BEHAVIOUR
//   Reset values: period_o=0, high_o=0, valid_o=0, busy_o=0, ovf_o=0, state=IDLE, sync FFs=0.
//   Input path: 2-FF synchronizer -> XOR pol_i -> (optional filter) -> level s; prev-level reg p.
//     rise = s & ~p, fall = ~s & p.
//   pol_i is registered on the cycle en_i goes 0->1; changes while en_i=1 are ignored.
//   Counter cnt (WIDTH bits): set to 1 on every rise; +1 per cycle otherwise; saturates at 2^WIDTH-1.
//   FSM:
//     IDLE: en_i=1 -> ARM (cnt=0, hold outputs).
//     ARM:  wait for rise; first rise after arming -> HIGH. No valid_o from ARM.
//     HIGH: fall -> latch high_r=cnt, -> LOW.
//     LOW:  rise -> period_o<=cnt, high_o<=high_r, valid_o=1 next cycle, -> HIGH.
//     Any state: en_i=0 -> IDLE next cycle.
//       - Clears cnt, high_r and ovf_o; period_o/high_o keep their last values.
//       - No valid_o is produced for a measurement that was aborted.
//   Example: input high 3 cycles, low 5 cycles -> period_o=8, high_o=3.
//   Latency: valid_o is registered and asserts 3 clk_psc_i cycles after the pin's rising transition is first sampled.
//     Both edges are delayed equally, so measured values are unaffected.
//   Boundaries:
//     - cnt == 2^WIDTH-1 with no edge in HIGH or LOW (0%/100% duty, stopped input) -> ovf_o<=1, state ARM.
//       The partial measurement is discarded; outputs are unchanged.
//     - Rise and fall cannot occur in the same cycle, by construction.
//     - Shortest measurable pulse is 1 cycle: high_o=1.
//     - A rise in the cycle the counter saturates is treated as an edge, not an overflow.
//     - Reset mid-measurement -> all reset values immediately, asynchronously.
// CONFIGURATION
//   PWM_CAP_FILTER_EN defined: the level s changes only after the polarity-adjusted sync output has been stable FILT_LEN consecutive cycles.
//     - Pulses shorter than FILT_LEN cycles are ignored.
//     - Edge latency grows by FILT_LEN cycles.
//   PWM_CAP_FILTER_EN undefined: no filter; s = polarity-adjusted sync output.
//     - Every 1-cycle pulse is measured.
// STRUCTURE
//   pwm_pkg: FSM state encodings (IDLE/ARM/HIGH/LOW, 2 bits) and the counter-max constant function of WIDTH.
//   Sub-module pwm_cap_sync_filter: synchronizer, polarity XOR, optional filter, rise/fall outputs.
//   pwm_capture: counter, FSM, output registers.
// TESTING
//   1. Reset, en_i=1, pol_i=0, pwm 3 high/5 low repeating -> first valid_o after the 2nd rise; period_o=8, high_o=3 on every pulse.
//   2. Same waveform with pol_i=1 -> period_o=8, high_o=5.
//   3. WIDTH=8, pwm held high 300 cycles -> ovf_o=1, no valid_o; then en_i 0->1 -> ovf_o=0.
//   4. en_i dropped mid-HIGH, re-enabled -> no valid_o until 2 full rises; prior period_o/high_o retained.
//   5. FILTER_EN, FILT_LEN=4, 2-cycle glitches inside a 10/10 waveform -> period_o=20, high_o=10.
//      Without FILTER_EN, the same stimulus measures the glitches.
//   6. rst_n_i asserted mid-LOW -> all outputs 0 the same cycle; recovery identical to scenario 1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture channel: FSM state encoding and
// the counter saturation value as a function of counter width.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } cap_state_t;

    // All-ones value of a width-bit counter (truncated by the caller).
    function automatic logic [63:0] cnt_max(input int unsigned width);
        if (width >= 64)
            cnt_max = '1;
        else
            cnt_max = (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/pwm_cap_sync_filter.sv
// Input conditioning for pwm_capture: 2-FF synchronizer, polarity inversion,
// optional glitch filter (PWM_CAP_FILTER_EN) and rise/fall edge detection.
module pwm_cap_sync_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk_psc_i,
    input  logic rst_n_i,
    input  logic pwm_i,
    input  logic pol_i,
    output logic rise_o,
    output logic fall_o
);

    if (FILT_LEN == 0) begin : g_bad_filt_len
        $error("pwm_cap_sync_filter: FILT_LEN must be at least 1");
    end

    logic [1:0] sync_q;
    logic       lvl;
    logic       s_q;
    logic       p_q;

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i)
            sync_q <= '0;
        else
            sync_q <= {sync_q[0], pwm_i};
    end

    assign lvl = sync_q[1] ^ pol_i;

`ifdef PWM_CAP_FILTER_EN
    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILT_LEN - 1);

    logic          lvl_q;
    logic [FW-1:0] flt_cnt;

    // lvl_q is the filter input so a change must persist FILT_LEN samples
    // before s_q follows, adding exactly FILT_LEN cycles of edge latency.
    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lvl_q   <= 1'b0;
            s_q     <= 1'b0;
            flt_cnt <= '0;
        end else begin
            lvl_q <= lvl;
            if (lvl_q == s_q) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                s_q     <= lvl_q;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i)
            s_q <= 1'b0;
        else
            s_q <= lvl;
    end
`endif

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i)
            p_q <= 1'b0;
        else
            p_q <= s_q;
    end

    assign rise_o = s_q & ~p_q;
    assign fall_o = ~s_q & p_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input-capture channel: measures period and active time of pwm_i in
// clk_psc_i cycles. Glitch filter selected by PWM_CAP_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic             clk_psc_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             pol_i,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] period_o,
    output logic [WIDTH-1:0] high_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));

    cap_state_t       state_q;
    cap_state_t       state_d;
    logic             en_q;
    logic             pol_q;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] high_q;
    logic             ld_high;
    logic             ld_out;
    logic             set_ovf;

    // Polarity is sampled only on the enabling edge of en_i.
    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q  <= 1'b0;
            pol_q <= 1'b0;
        end else begin
            en_q <= en_i;
            if (en_i && !en_q)
                pol_q <= pol_i;
        end
    end

    pwm_cap_sync_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_sync_filter (
        .clk_psc_i (clk_psc_i),
        .rst_n_i   (rst_n_i),
        .pwm_i     (pwm_i),
        .pol_i     (pol_q),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // An edge seen in the saturating cycle wins over the overflow.
    always_comb begin
        state_d = state_q;
        ld_high = 1'b0;
        ld_out  = 1'b0;
        set_ovf = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (rise)
                        state_d = ST_HIGH;
                end
                ST_HIGH: begin
                    if (fall) begin
                        ld_high = 1'b1;
                        state_d = ST_LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        set_ovf = 1'b1;
                        state_d = ST_ARM;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        ld_out  = 1'b1;
                        state_d = ST_HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        set_ovf = 1'b1;
                        state_d = ST_ARM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else if (!en_i || state_q == ST_IDLE)
            cnt_q <= '0;
        else if (rise)
            cnt_q <= WIDTH'(1);
        else if (cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i)
            high_q <= '0;
        else if (!en_i)
            high_q <= '0;
        else if (ld_high)
            high_q <= cnt_q;
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            period_o <= '0;
            high_o   <= '0;
            valid_o  <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            valid_o <= ld_out;
            if (ld_out) begin
                period_o <= cnt_q;
                high_o   <= high_q;
            end
            if (!en_i)
                ovf_o <= 1'b0;
            else if (set_ovf)
                ovf_o <= 1'b1;
        end
    end

    assign busy_o = (state_q == ST_HIGH) || (state_q == ST_LOW);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture: a 16-bit and an 8-bit instance share stimulus.
module tb_pwm_capture;

`ifdef PWM_CAP_FILTER_EN
    localparam int FL = 4;
    localparam int HI = 6;
    localparam int LO = 10;
`else
    localparam int FL = 0;
    localparam int HI = 3;
    localparam int LO = 5;
`endif
    localparam int PER = HI + LO;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        pol = 1'b0;
    logic        pwm = 1'b0;
    logic [15:0] period, high;
    logic        valid, busy, ovf;
    logic [7:0]  period8, high8;
    logic        valid8, busy8, ovf8;

    int          vectors = 0;
    int          errors = 0;
    int          nval = 0, nval8 = 0, cyc_no = 0, vcyc = 0;
    logic [15:0] vp = '0, vh = '0;
    logic [7:0]  vp8 = '0, vh8 = '0;

    always #5 clk = ~clk;

    pwm_capture #(.WIDTH(16), .FILT_LEN(4)) dut (
        .clk_psc_i(clk), .rst_n_i(rst_n), .en_i(en), .pol_i(pol), .pwm_i(pwm),
        .period_o(period), .high_o(high), .valid_o(valid), .busy_o(busy), .ovf_o(ovf)
    );

    pwm_capture #(.WIDTH(8), .FILT_LEN(4)) dut8 (
        .clk_psc_i(clk), .rst_n_i(rst_n), .en_i(en), .pol_i(pol), .pwm_i(pwm),
        .period_o(period8), .high_o(high8), .valid_o(valid8), .busy_o(busy8), .ovf_o(ovf8)
    );

    // One clock with pwm held at lvl; records any valid pulse seen after the edge.
    task automatic cyc(input logic lvl);
        pwm = lvl;
        @(posedge clk);
        #1;
        cyc_no++;
        if (valid) begin nval++; vp = period; vh = high; vcyc = cyc_no; end
        if (valid8) begin nval8++; vp8 = period8; vh8 = high8; end
    endtask

    task automatic cycles(input int n, input logic lvl);
        repeat (n) cyc(lvl);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; pwm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (period !== 16'd0) begin errors++; $display("FAIL rst_period got %0d want 0", period); end
        vectors++; if (high !== 16'd0) begin errors++; $display("FAIL rst_high got %0d want 0", high); end
        vectors++; if ({valid, busy, ovf} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {valid, busy, ovf}); end
        rst_n = 1'b1;
        cycles(2, 1'b0);
    endtask

    task automatic test_basic(input string tag);
        int start;
        en = 1'b0; pol = 1'b0;
        cycles(8, 1'b0);
        en = 1'b1;
        cycles(8, 1'b0);
        nval = 0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_arm_busy got %b want 0", tag, busy); end
        for (int p = 0; p < 6; p++) begin
            start = cyc_no;
            cycles(HI, 1'b1);
            cycles(LO, 1'b0);
            if (p == 0) begin
                vectors++; if (nval !== 0) begin errors++; $display("FAIL %s_first_valid got %0d pulses want 0", tag, nval); end
            end else begin
                vectors++; if (nval !== p) begin errors++; $display("FAIL %s_count p%0d got %0d want %0d", tag, p, nval, p); end
                vectors++; if (vp !== 16'(PER)) begin errors++; $display("FAIL %s_period p%0d got %0d want %0d", tag, p, vp, PER); end
                vectors++; if (vh !== 16'(HI)) begin errors++; $display("FAIL %s_high p%0d got %0d want %0d", tag, p, vh, HI); end
                vectors++; if (vcyc - start !== 4 + FL) begin errors++; $display("FAIL %s_latency p%0d got %0d want %0d", tag, p, vcyc - start, 4 + FL); end
            end
        end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", tag, busy); end
    endtask

    task automatic test_polarity;
        en = 1'b0; pol = 1'b0;
        cycles(8, 1'b1);
        pol = 1'b1; en = 1'b1;
        cycles(8, 1'b1);
        nval = 0;
        for (int p = 0; p < 4; p++) begin
            if (p == 2) pol = 1'b0;  // ignored while enabled
            cycles(HI, 1'b1);
            cycles(LO, 1'b0);
            if (p == 0) begin
                vectors++; if (nval !== 0) begin errors++; $display("FAIL pol_first_valid got %0d want 0", nval); end
            end else begin
                vectors++; if (nval !== p) begin errors++; $display("FAIL pol_count p%0d got %0d want %0d", p, nval, p); end
                vectors++; if (vp !== 16'(PER)) begin errors++; $display("FAIL pol_period p%0d got %0d want %0d", p, vp, PER); end
                vectors++; if (vh !== 16'(LO)) begin errors++; $display("FAIL pol_high p%0d got %0d want %0d", p, vh, LO); end
            end
        end
    endtask

    task automatic test_overflow;
        en = 1'b0; pol = 1'b0;
        cycles(8, 1'b0);
        en = 1'b1;
        cycles(8, 1'b0);
        nval = 0; nval8 = 0;
        cycles(258 + FL, 1'b1);
        vectors++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf8); end
        cyc(1'b1);
        vectors++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf8); end
        vectors++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ovf_busy8 got %b want 0", busy8); end
        vectors++; if (period8 !== 8'(PER) || high8 !== 8'(LO)) begin errors++; $display("FAIL ovf_hold got %0d/%0d want %0d/%0d", period8, high8, PER, LO); end
        vectors++; if (ovf !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovf_wide got ovf=%b busy=%b want 0/1", ovf, busy); end
        cycles(41 - FL, 1'b1);
        vectors++; if (ovf8 !== 1'b1 || nval8 !== 0) begin errors++; $display("FAIL ovf_sticky got ovf=%b pulses=%0d want 1/0", ovf8, nval8); end
        cycles(8, 1'b0);
        en = 1'b0;
        cyc(1'b0);
        vectors++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf8); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy got %b want 0", busy); end
        cycles(2, 1'b0);
    endtask

    task automatic test_saturate_edge;
        en = 1'b1;
        cycles(8, 1'b0);
        nval8 = 0;
        repeat (2) begin
            cycles(5, 1'b1);
            cycles(250, 1'b0);
        end
        cycles(5, 1'b1);
        cycles(10, 1'b0);
        vectors++; if (nval8 !== 2) begin errors++; $display("FAIL sat_count got %0d want 2", nval8); end
        vectors++; if (vp8 !== 8'd255 || vh8 !== 8'd5) begin errors++; $display("FAIL sat_edge got %0d/%0d want 255/5", vp8, vh8); end
        vectors++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL sat_ovf got %b want 0", ovf8); end
        vectors++; if (vp !== 16'd255) begin errors++; $display("FAIL sat_wide got %0d want 255", vp); end
    endtask

    task automatic test_abort;
        nval = 0;
        cycles(10, 1'b0);
        cycles(10, 1'b1);
        vectors++; if (nval !== 1 || vp !== 16'd25 || vh !== 16'd5) begin errors++; $display("FAIL abort_pre got n=%0d %0d/%0d want 1 25/5", nval, vp, vh); end
        en = 1'b0;
        cycles(3, 1'b1);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        vectors++; if (period !== 16'd25 || high !== 16'd5) begin errors++; $display("FAIL abort_hold got %0d/%0d want 25/5", period, high); end
        en = 1'b1;
        cycles(10, 1'b1);
        cycles(LO, 1'b0);
        vectors++; if (nval !== 1) begin errors++; $display("FAIL abort_novalid got %0d want 1", nval); end
        for (int p = 0; p < 3; p++) begin
            cycles(HI, 1'b1);
            cycles(LO, 1'b0);
            if (p == 0) begin
                vectors++; if (nval !== 1 || period !== 16'd25) begin errors++; $display("FAIL abort_rearm got n=%0d period=%0d want 1/25", nval, period); end
            end else begin
                vectors++; if (nval !== 1 + p || vp !== 16'(PER) || vh !== 16'(HI)) begin errors++; $display("FAIL abort_resume p%0d got n=%0d %0d/%0d want %0d %0d/%0d", p, nval, vp, vh, 1 + p, PER, HI); end
            end
        end
    endtask

    task automatic test_glitch;
        en = 1'b0;
        cycles(8, 1'b0);
        en = 1'b1;
        cycles(8, 1'b0);
        nval = 0;
        repeat (4) begin
            cycles(4, 1'b1); cycles(2, 1'b0); cycles(4, 1'b1);
            cycles(4, 1'b0); cycles(2, 1'b1); cycles(4, 1'b0);
        end
`ifdef PWM_CAP_FILTER_EN
        vectors++; if (nval !== 3) begin errors++; $display("FAIL glitch_count got %0d want 3", nval); end
        vectors++; if (vp !== 16'd20 || vh !== 16'd10) begin errors++; $display("FAIL glitch_meas got %0d/%0d want 20/10", vp, vh); end
`else
        vectors++; if (nval !== 11) begin errors++; $display("FAIL glitch_count got %0d want 11", nval); end
        vectors++; if (vp !== 16'd8 || vh !== 16'd4) begin errors++; $display("FAIL glitch_meas got %0d/%0d want 8/4", vp, vh); end
`endif
    endtask

    task automatic test_reset_mid;
        cycles(HI, 1'b1);
        cycles(LO - 1, 1'b0);
        vectors++; if (busy !== 1'b1 || period === 16'd0) begin errors++; $display("FAIL mid_pre got busy=%b period=%0d want 1/nonzero", busy, period); end
        rst_n = 1'b0;
        #2;
        vectors++; if (period !== 16'd0 || high !== 16'd0) begin errors++; $display("FAIL mid_rst_vals got %0d/%0d want 0/0", period, high); end
        vectors++; if ({valid, busy, ovf} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags got %b want 000", {valid, busy, ovf}); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_basic("recover");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic("basic");
        test_polarity();
        test_overflow();
        test_saturate_edge();
        test_abort();
        test_glitch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
